// File: rtl/prog_loader.sv
// Serial program loader: length-prefixed byte stream into 32-bit instruction memory words,
// XOR-checksum verified, holding the CPU in reset until a good load completes.
module prog_loader #(
  parameter int unsigned AW = 8,
  parameter int unsigned WD = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [WD-1:0] mem_wdata,
  output logic          cpu_rst,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int unsigned LW  = 16;
  localparam int unsigned CAP = 32'd1 << AW;

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   wcnt_q, wcnt_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [23:0]     word_q, word_d;
  logic [7:0]      xor_q, xor_d;
  logic            we_d, rdy_d, busy_d, cpu_rst_d, done_d, err_d;
  logic [AW-1:0]   addr_d;
  logic [WD-1:0]   wdata_d;
  logic            fire;
  logic [LW-1:0]   len_new;
  logic            rx_next;

  assign fire    = byte_valid && byte_ready;
  assign len_new = {byte_data, len_q[7:0]};

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      wcnt_q     <= '0;
      bcnt_q     <= '0;
      word_q     <= '0;
      xor_q      <= '0;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rst    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wcnt_q     <= wcnt_d;
      bcnt_q     <= bcnt_d;
      word_q     <= word_d;
      xor_q      <= xor_d;
      byte_ready <= rdy_d;
      mem_we     <= we_d;
      mem_addr   <= addr_d;
      mem_wdata  <= wdata_d;
      cpu_rst    <= cpu_rst_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

  // Next state, datapath and next output values
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    xor_d   = xor_q;
    we_d    = 1'b0;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = LEN_LO;
          xor_d   = '0;
          wcnt_d  = '0;
          bcnt_d  = '0;
        end
      end
      LEN_LO: begin
        if (fire) begin
          len_d   = LW'(byte_data);
          xor_d   = xor_q ^ byte_data;
          state_d = LEN_HI;
        end
      end
      LEN_HI: begin
        if (fire) begin
          len_d = len_new;
          xor_d = xor_q ^ byte_data;
          if (32'(len_new) > CAP)   state_d = ERR;
          else if (len_new == '0)   state_d = CSUM;
          else                      state_d = DATA;
        end
      end
      DATA: begin
        if (fire) begin
          xor_d  = xor_q ^ byte_data;
          bcnt_d = bcnt_q + 2'd1;
          word_d = {byte_data, word_q[23:8]};
          // Fourth byte completes a little-endian word; write it next cycle
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = AW'(wcnt_q);
            wdata_d = WD'({byte_data, word_q});
            wcnt_d  = wcnt_q + 16'd1;
            if (wcnt_d == len_q) state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (fire) state_d = (byte_data == xor_q) ? DONE : ERR;
      end
      default: state_d = IDLE;
    endcase

    rx_next   = (state_d == LEN_LO) || (state_d == LEN_HI) ||
                (state_d == DATA)   || (state_d == CSUM);
    rdy_d     = rx_next && !we_d;
    busy_d    = rx_next;
    cpu_rst_d = (state_d != DONE);
    done_d    = (state_d == DONE);
    err_d     = (state_d == ERR);
  end

endmodule
